// File: rtl/vec_op_sched.sv
// rtl/vec_op_sched.sv - round-robin scheduler sharing one fixed-latency vector datapath
//
// Purpose: arbitrates NUM_REQ requesters onto one two-operand datapath, one issue
// per cycle, tracks each issued ID through the datapath latency and routes the
// result back to its owner. Enable/drain control stops issue and waits for empty.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   enable              1 = issue allowed, 0 = stop issue and drain
//   req_valid/ready     per-requester handshake (ready is one-hot or zero)
//   req_data_a/b        packed operands, requester i at [i*DW +: DW]
//   dp_valid, dp_data_a/b  operand pair to the datapath
//   dp_data_out         datapath result, PIPE_LAT cycles after dp_valid
//   rsp_valid, rsp_data one-hot result strobe and result data
//   inflight            operations accepted but not yet returned
//   drained             1 while idle
//   issue_cnt           wrapping count of accepted operations
module vec_op_sched #(
  parameter int DATA_WIDTH_BIT = 512,
  parameter int NUM_REQ        = 4,
  parameter int PIPE_LAT       = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enable,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ*DATA_WIDTH_BIT-1:0] req_data_a,
  input  logic [NUM_REQ*DATA_WIDTH_BIT-1:0] req_data_b,
  output logic                              dp_valid,
  output logic [DATA_WIDTH_BIT-1:0]         dp_data_a,
  output logic [DATA_WIDTH_BIT-1:0]         dp_data_b,
  input  logic [DATA_WIDTH_BIT-1:0]         dp_data_out,
  output logic [NUM_REQ-1:0]                rsp_valid,
  output logic [DATA_WIDTH_BIT-1:0]         rsp_data,
  output logic [$clog2(NUM_REQ)+1:0]        inflight,
  output logic                              drained,
  output logic [31:0]                       issue_cnt
);

  localparam int DW    = DATA_WIDTH_BIT;
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = ID_W + 2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t              state;
  logic [ID_W-1:0]     rr_ptr;
  logic                grant_vld;
  logic [ID_W-1:0]     grant_id;
  logic [ID_W-1:0]     next_ptr;
  logic [ID_W-1:0]     cand;
  int                  arb_idx;
  logic [DW-1:0]       sel_a;
  logic [DW-1:0]       sel_b;
  logic [ID_W-1:0]     dp_id;
  logic [PIPE_LAT-1:0] stage_vld;
  logic [ID_W-1:0]     stage_id [PIPE_LAT];
  logic                head_vld;
  logic [ID_W-1:0]     head_id;
  logic [NUM_REQ-1:0]  head_onehot;

  // Search upward from the pointer, wrapping; the first valid requester wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    arb_idx   = 0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      arb_idx = int'(rr_ptr) + k;
      if (arb_idx >= NUM_REQ) arb_idx = arb_idx - NUM_REQ;
      cand = ID_W'(arb_idx);
      if (!grant_vld && req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_id  = cand;
      end
    end
    if (state != S_RUN) grant_vld = 1'b0;
  end

  always_comb begin
    req_ready = '0;
    if (grant_vld) req_ready[grant_id] = 1'b1;
  end

  assign next_ptr = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        sel_a = req_data_a[i*DW +: DW];
        sel_b = req_data_b[i*DW +: DW];
      end
    end
  end

  // Last stage of the ID pipe lines up with dp_data_out for that operation.
  assign head_vld = stage_vld[PIPE_LAT-1];
  assign head_id  = stage_id[PIPE_LAT-1];

  always_comb begin
    head_onehot          = '0;
    head_onehot[head_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      drained   <= 1'b1;
      rr_ptr    <= '0;
      dp_valid  <= 1'b0;
      dp_data_a <= '0;
      dp_data_b <= '0;
      dp_id     <= '0;
      stage_vld <= '0;
      for (int k = 0; k < PIPE_LAT; k++) stage_id[k] <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      inflight  <= '0;
      issue_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (enable) begin
            state   <= S_RUN;
            drained <= 1'b0;
          end
        end
        S_RUN: begin
          if (!enable) state <= S_DRAIN;
        end
        S_DRAIN: begin
          // Enable is ignored here; the pipe must empty before RUN again.
          if (inflight == '0) begin
            state   <= S_IDLE;
            drained <= 1'b1;
          end
        end
        default: begin
          state   <= S_IDLE;
          drained <= 1'b1;
        end
      endcase

      dp_valid <= grant_vld;
      if (grant_vld) begin
        rr_ptr    <= next_ptr;
        dp_id     <= grant_id;
        dp_data_a <= sel_a;
        dp_data_b <= sel_b;
        issue_cnt <= issue_cnt + 32'd1;
      end

      stage_vld[0] <= dp_valid;
      stage_id[0]  <= dp_id;
      for (int k = PIPE_LAT - 1; k > 0; k--) begin
        stage_vld[k] <= stage_vld[k-1];
        stage_id[k]  <= stage_id[k-1];
      end

      rsp_valid <= head_vld ? head_onehot : '0;
      if (head_vld) rsp_data <= dp_data_out;

      // An operation stays counted through its rsp_valid cycle.
      case ({grant_vld, |rsp_valid})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_op_sched.sv
// tb/tb_vec_op_sched.sv - self-checking bench for vec_op_sched
module tb_vec_op_sched;
  localparam int DW   = 512;
  localparam int NR   = 4;
  localparam int PL   = 3;
  localparam int ID_W = 2;
  localparam int CW   = ID_W + 2;

  logic             clk;
  logic             rst;
  logic             enable;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR*DW-1:0] req_data_a;
  logic [NR*DW-1:0] req_data_b;
  logic             dp_valid;
  logic [DW-1:0]    dp_data_a;
  logic [DW-1:0]    dp_data_b;
  logic [DW-1:0]    dp_data_out;
  logic [NR-1:0]    rsp_valid;
  logic [DW-1:0]    rsp_data;
  logic [CW-1:0]    inflight;
  logic             drained;
  logic [31:0]      issue_cnt;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int rsp_seen = 0;

  typedef struct { logic [DW-1:0] a; logic [DW-1:0] b; } op_t;
  typedef struct { logic [NR-1:0] onehot; logic [DW-1:0] sum; int due; } exp_t;
  typedef struct { logic [NR-1:0] valid; logic [NR-1:0] ready; } vec_t;

  op_t  dp_q  [$];
  exp_t rsp_q [$];

  vec_op_sched #(.DATA_WIDTH_BIT(DW), .NUM_REQ(NR), .PIPE_LAT(PL)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data_a(req_data_a), .req_data_b(req_data_b),
    .dp_valid(dp_valid), .dp_data_a(dp_data_a), .dp_data_b(dp_data_b),
    .dp_data_out(dp_data_out),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .inflight(inflight), .drained(drained), .issue_cnt(issue_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Datapath stand-in: a + b with PL cycles of latency.
  logic [DW-1:0] dp_pipe [PL];
  always @(posedge clk) begin
    dp_pipe[0] <= dp_valid ? dp_data_a + dp_data_b : '1;
    for (int k = 1; k < PL; k++) dp_pipe[k] <= dp_pipe[k-1];
  end
  assign dp_data_out = dp_pipe[PL-1];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_extra(input string name);
    checks++;
    failures++;
    $display("FAIL %s: output seen with nothing outstanding (required none)", name);
  endtask

  // Scoreboard monitor: outputs checked first, then new handshakes pushed.
  always @(negedge clk) begin
    op_t  o;
    exp_t e;
    logic [NR-1:0] oh;
    if (dp_valid) begin
      if (dp_q.size() == 0) fail_extra("dp_unexpected");
      else begin
        o = dp_q.pop_front();
        chk("dp_data_a", dp_data_a, o.a);
        chk("dp_data_b", dp_data_b, o.b);
      end
    end
    if (|rsp_valid) begin
      rsp_seen++;
      if (rsp_q.size() == 0) fail_extra("rsp_unexpected");
      else begin
        e = rsp_q.pop_front();
        chk("rsp_id", DW'(rsp_valid), DW'(e.onehot));
        chk("rsp_data", rsp_data, e.sum);
        chk("rsp_latency", DW'(cyc), DW'(e.due));
      end
    end
    chk("ready_onehot0", DW'($onehot0(req_ready)), DW'(1));
    chk("ready_without_valid", DW'(req_ready & ~req_valid), '0);
    if (rst) begin
      dp_q.delete();
      rsp_q.delete();
    end else begin
      for (int i = 0; i < NR; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          oh    = '0;
          oh[i] = 1'b1;
          dp_q.push_back('{a: req_data_a[i*DW +: DW], b: req_data_b[i*DW +: DW]});
          rsp_q.push_back('{onehot: oh,
                            sum: req_data_a[i*DW +: DW] + req_data_b[i*DW +: DW],
                            due: cyc + PL + 2});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rand_data();
    for (int i = 0; i < NR*DW/32; i++) begin
      req_data_a[i*32 +: 32] = $urandom;
      req_data_b[i*32 +: 32] = $urandom;
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_ready"},     DW'(req_ready), '0);
    chk({tag, "_dp_valid"},  DW'(dp_valid), '0);
    chk({tag, "_dp_data_a"}, dp_data_a, '0);
    chk({tag, "_rsp_valid"}, DW'(rsp_valid), '0);
    chk({tag, "_rsp_data"},  rsp_data, '0);
    chk({tag, "_inflight"},  DW'(inflight), '0);
    chk({tag, "_drained"},   DW'(drained), DW'(1));
    chk({tag, "_issue_cnt"}, DW'(issue_cnt), '0);
  endtask

  task automatic start_run();
    rst       = 1'b1;
    enable    = 1'b0;
    req_valid = '0;
    tick();
    tick();
    rst    = 1'b0;
    enable = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

  vec_t tbl [13];
  int   n_issue;
  int   hs_cyc;
  int   zero_cyc;
  int   rsp_base;
  logic got;

  initial begin
    tbl[0]  = '{4'b1111, 4'b0001};
    tbl[1]  = '{4'b1111, 4'b0010};
    tbl[2]  = '{4'b1010, 4'b1000};
    tbl[3]  = '{4'b1010, 4'b0010};
    tbl[4]  = '{4'b0100, 4'b0100};
    tbl[5]  = '{4'b0000, 4'b0000};
    tbl[6]  = '{4'b0001, 4'b0001};
    tbl[7]  = '{4'b1000, 4'b1000};
    tbl[8]  = '{4'b0110, 4'b0010};
    tbl[9]  = '{4'b0000, 4'b0000};
    tbl[10] = '{4'b1101, 4'b0100};
    tbl[11] = '{4'b1101, 4'b1000};
    tbl[12] = '{4'b0011, 4'b0001};

    rst        = 1'b1;
    enable     = 1'b0;
    req_valid  = '0;
    req_data_a = '0;
    req_data_b = '0;
    tick();
    tick();
    @(negedge clk);
    check_reset_state("reset");

    // Single op: 5 + 7 from requester 0.
    rst    = 1'b0;
    enable = 1'b1;
    tick();
    req_valid = 4'b0001;
    req_data_a[DW-1:0] = DW'(5);
    req_data_b[DW-1:0] = DW'(7);
    @(negedge clk);
    chk("t1_ready", DW'(req_ready), DW'(4'b0001));
    hs_cyc = cyc;
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("t1_dp_valid", DW'(dp_valid), DW'(1));
    chk("t1_dp_a", dp_data_a, DW'(5));
    chk("t1_dp_b", dp_data_b, DW'(7));
    chk("t1_inflight_1", DW'(inflight), DW'(1));
    got = 1'b0;
    for (int k = 0; k < 12 && !got; k++) begin
      @(negedge clk);
      if (|rsp_valid) got = 1'b1;
    end
    chk("t1_rsp_seen", DW'(got), DW'(1));
    chk("t1_rsp_valid", DW'(rsp_valid), DW'(4'b0001));
    chk("t1_rsp_data", rsp_data, DW'(12));
    chk("t1_latency", DW'(cyc - hs_cyc), DW'(PL + 2));
    @(negedge clk);
    chk("t1_inflight_0", DW'(inflight), '0);

    // Table of arbitration vectors, pointer starting at 0.
    start_run();
    n_issue = 0;
    for (int i = 0; i < 13; i++) begin
      req_valid = tbl[i].valid;
      set_rand_data();
      @(negedge clk);
      chk($sformatf("rr_vec%0d", i), DW'(req_ready), DW'(tbl[i].ready));
      if (tbl[i].ready != '0) n_issue++;
      tick();
    end
    req_valid = '0;
    repeat (PL + 4) tick();
    @(negedge clk);
    chk("tbl_issue_cnt", DW'(issue_cnt), DW'(n_issue));
    chk("tbl_inflight", DW'(inflight), '0);

    // Fairness: all requesters valid for 8 cycles.
    start_run();
    rsp_base  = rsp_seen;
    set_rand_data();
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("fair_grant%0d", k), DW'(req_ready), DW'(4'b0001 << (k % 4)));
      if (k == 6) chk("fair_inflight_max", DW'(inflight), DW'(PL + 2));
      tick();
    end
    req_valid = '0;
    @(negedge clk);
    chk("fair_issue_cnt", DW'(issue_cnt), DW'(8));
    repeat (PL + 4) tick();
    @(negedge clk);
    chk("fair_rsp_count", DW'(rsp_seen - rsp_base), DW'(8));
    chk("fair_inflight_0", DW'(inflight), '0);

    // Drain: 3 issues, enable drops with the third, re-raised during drain.
    start_run();
    rsp_base  = rsp_seen;
    set_rand_data();
    req_valid = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) enable = 1'b0;
      @(negedge clk);
      chk($sformatf("drain_grant%0d", k), DW'(req_ready), DW'(4'b0001 << k));
      tick();
    end
    enable   = 1'b1;
    zero_cyc = -100;
    got      = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (drained) begin
        got = 1'b1;
        chk("drain_idle_after_zero", DW'(cyc - zero_cyc), DW'(1));
        chk("drain_idle_ready", DW'(req_ready), '0);
        chk("drain_rsp_count", DW'(rsp_seen - rsp_base), DW'(3));
      end else begin
        chk("drain_ready_zero", DW'(req_ready), '0);
        if (inflight == '0 && zero_cyc < 0) zero_cyc = cyc;
      end
    end
    chk("drain_reached_idle", DW'(got), DW'(1));
    tick();
    @(negedge clk);
    chk("drain_rerun_grant", DW'(req_ready), DW'(4'b1000));
    tick();
    req_valid = '0;
    repeat (PL + 4) tick();

    // Reset with two operations in flight.
    start_run();
    set_rand_data();
    req_valid = 4'b0011;
    tick();
    tick();
    req_valid = '0;
    tick();
    rst    = 1'b1;
    enable = 1'b0;
    tick();
    @(negedge clk);
    check_reset_state("midrst");
    rst      = 1'b0;
    rsp_base = rsp_seen;
    repeat (10) tick();
    @(negedge clk);
    chk("midrst_no_rsp", DW'(rsp_seen - rsp_base), '0);

    // issue_cnt wrap.
    start_run();
    @(negedge clk);
    force dut.issue_cnt = 32'hFFFF_FFFF;
    tick();
    release dut.issue_cnt;
    set_rand_data();
    req_valid = 4'b0001;
    @(negedge clk);
    chk("wrap_pre", DW'(issue_cnt), DW'(32'hFFFF_FFFF));
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("wrap_post", DW'(issue_cnt), '0);
    repeat (PL + 4) tick();
    @(negedge clk);
    chk("end_rsp_q_empty", DW'(rsp_q.size()), '0);
    chk("end_dp_q_empty", DW'(dp_q.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
